// File: rtl/otter_pc_redirect_if.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pc_redirect_if
//  Description : Bundle of the EX-stage redirect inputs, the instruction
//                memory read port and the IF-stage outputs of the OTTER
//                fetch unit.
//                slave  : fetch unit side (otter_pc_redirect)
//                master : pipeline / memory side
//  Signals     : ex_valid, pcSource[2:0], jalr_tgt, branch_tgt, jal_tgt,
//                mtvec, mepc, stall           (pipeline -> fetch)
//                imem_addr, imem_rden         (fetch -> memory)
//                imem_rdata                   (memory -> fetch)
//                if_instr, if_pc, if_valid,
//                flush_ifid, flush_idex,
//                misalign_err, redirect_cnt   (fetch -> pipeline)
//  Revision    : 1.0 - initial release
// ============================================================================
interface otter_pc_redirect_if;
    logic        ex_valid;
    logic [2:0]  pcSource;
    logic [31:0] jalr_tgt;
    logic [31:0] branch_tgt;
    logic [31:0] jal_tgt;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        stall;
    logic [31:0] imem_addr;
    logic        imem_rden;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misalign_err;
    logic [31:0] redirect_cnt;

    modport slave (
        input  ex_valid, pcSource, jalr_tgt, branch_tgt, jal_tgt, mtvec, mepc,
               stall, imem_rdata,
        output imem_addr, imem_rden, if_instr, if_pc, if_valid,
               flush_ifid, flush_idex, misalign_err, redirect_cnt
    );

    modport master (
        output ex_valid, pcSource, jalr_tgt, branch_tgt, jal_tgt, mtvec, mepc,
               stall, imem_rdata,
        input  imem_addr, imem_rden, if_instr, if_pc, if_valid,
               flush_ifid, flush_idex, misalign_err, redirect_cnt
    );
endinterface
`default_nettype wire

// File: rtl/otter_pc_redirect.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pc_redirect
//  Description : OTTER fetch-side program counter. Consumes the EX-stage
//                pcSource code, selects the next PC, drives the synchronous
//                instruction memory, squashes wrong-path instructions after a
//                taken redirect, honours hazard stalls and traps misaligned
//                redirect targets (sticky until reset).
//  Ports       : CLK  - clock, all state on rising edge
//                RST  - asynchronous active-high reset
//                bus  - otter_pc_redirect_if.slave (EX redirect inputs,
//                       imem read port, IF outputs, flushes, status)
//  Parameters  : RESET_VEC - PC loaded on reset
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_pc_redirect #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    otter_pc_redirect_if.slave bus
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] c_PC_STEP = 32'd4;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic        r_if_valid;
    logic        r_err;
    logic [31:0] r_cnt;

    logic        w_take;
    logic [31:0] w_tgt;
    logic        w_active;
    logic        w_redirect;

    // Target selection; codes 0, 6 and 7 never redirect so their value is moot.
    always_comb begin
        w_tgt = 32'h0000_0000;
        case (bus.pcSource)
            3'd1:    w_tgt = bus.jalr_tgt;
            3'd2:    w_tgt = bus.branch_tgt;
            3'd3:    w_tgt = bus.jal_tgt;
            3'd4:    w_tgt = bus.mtvec;
            3'd5:    w_tgt = bus.mepc;
            default: w_tgt = 32'h0000_0000;
        endcase
    end

    assign w_take     = bus.ex_valid && (bus.pcSource != 3'd0) && (bus.pcSource <= 3'd5);
    // EX redirects are only acted on once fetch is running; BOOT has an empty
    // pipeline and FAULT is frozen until reset.
    assign w_active   = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign w_redirect = w_active && w_take;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VEC;
            r_if_pc    <= 32'h0000_0000;
            r_if_valid <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= 32'h0000_0000;
        end else begin
            case (r_state)
                // BOOT issues the first read at RESET_VEC; pc is not advanced
                // here, so the next cycle re-issues the same address.
                S_BOOT: begin
                    r_if_pc    <= r_pc;
                    r_if_valid <= 1'b1;
                    r_state    <= S_RUN;
                end

                // FLUSH differs from RUN only in that the data arriving during
                // it is wrong-path; r_if_valid was already cleared on the
                // redirect edge, so the next-state logic is shared.
                S_RUN, S_FLUSH: begin
                    if (w_take) begin
                        // Redirect beats a simultaneous stall.
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b0;
                        if (w_tgt[1:0] == 2'b00) begin
                            r_pc    <= w_tgt;
                            r_cnt   <= r_cnt + 32'd1;
                            r_state <= S_FLUSH;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_FAULT;
                        end
                    end else if (bus.stall) begin
                        // Hold pc, if_pc and if_valid; the same address is
                        // re-read next cycle.
                        r_state <= S_RUN;
                    end else begin
                        r_pc       <= r_pc + c_PC_STEP;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end

                S_FAULT: begin
                    r_state <= S_FAULT;
                end

                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign bus.imem_addr    = r_pc;
    assign bus.imem_rden    = !RST && (r_state != S_FAULT);
    assign bus.if_instr     = bus.imem_rdata;
    assign bus.if_pc        = r_if_pc;
    assign bus.if_valid     = r_if_valid;
    assign bus.flush_ifid   = RST || (r_state == S_FAULT) || w_redirect;
    assign bus.flush_idex   = RST || (r_state == S_FAULT) || w_redirect;
    assign bus.misalign_err = r_err;
    assign bus.redirect_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_otter_pc_redirect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otter_pc_redirect
//  Description : Self-checking bench for otter_pc_redirect. A behavioural
//                fetch model (pc, last fetched pc, validity, counters) tracks
//                the expected outputs; a synchronous memory model returns a
//                known pattern per address.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_otter_pc_redirect;

    localparam logic [31:0] C_RESET_VEC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    otter_pc_redirect_if bus();

    otter_pc_redirect #(.RESET_VEC(C_RESET_VEC)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    always @(posedge clk) if (bus.imem_rden) bus.imem_rdata <= memval(bus.imem_addr);

    int checks   = 0;
    int failures = 0;

    // Behavioural model
    logic [31:0] m_pc, m_if_pc, m_cnt;
    logic        m_ifv, m_err, m_fault, m_boot, m_last_take, m_held;

    function automatic logic exp_take();
        return bus.ex_valid && (bus.pcSource >= 3'd1) && (bus.pcSource <= 3'd5);
    endfunction

    function automatic logic [31:0] exp_tgt();
        case (bus.pcSource)
            3'd1:    return bus.jalr_tgt;
            3'd2:    return bus.branch_tgt;
            3'd3:    return bus.jal_tgt;
            3'd4:    return bus.mtvec;
            3'd5:    return bus.mepc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_flush();
        return rst || m_fault || (!m_boot && exp_take());
    endfunction

    task automatic model_reset();
        m_pc = C_RESET_VEC; m_if_pc = 32'h0; m_cnt = 32'h0;
        m_ifv = 1'b0; m_err = 1'b0; m_fault = 1'b0; m_boot = 1'b1;
        m_last_take = 1'b0; m_held = 1'b0;
    endtask

    task automatic model_update();
        logic [31:0] tgt;
        tgt    = exp_tgt();
        m_held = 1'b0;
        if (m_fault) begin
        end else if (m_boot) begin
            m_boot = 1'b0; m_if_pc = m_pc; m_ifv = 1'b1; m_last_take = 1'b0;
        end else if (exp_take()) begin
            m_if_pc = m_pc; m_ifv = 1'b0; m_last_take = 1'b1;
            if (tgt[1:0] != 2'b00) begin
                m_fault = 1'b1; m_err = 1'b1;
            end else begin
                m_pc = tgt; m_cnt = m_cnt + 32'd1;
            end
        end else if (bus.stall) begin
            m_held = 1'b1; m_last_take = 1'b0;
        end else begin
            m_if_pc = m_pc; m_pc = m_pc + 32'd4; m_ifv = 1'b1; m_last_take = 1'b0;
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus.ex_valid = 1'b0; bus.pcSource = 3'd0; bus.stall = 1'b0;
    endtask

    task automatic drive(input logic ev, input logic [2:0] src, input logic st);
        bus.ex_valid = ev; bus.pcSource = src; bus.stall = st;
    endtask

    task automatic advance_to(input logic [31:0] a);
        int n;
        n = 0;
        idle();
        while (m_pc != a && n < 300) begin
            clk_edge();
            n++;
        end
        checks++;
        if (bus.imem_addr !== a) begin
            failures++;
            $display("FAIL advance_to addr=%h required=%h", bus.imem_addr, a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.jalr_tgt = 0; bus.branch_tgt = 0; bus.jal_tgt = 0; bus.mtvec = 0; bus.mepc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.imem_addr !== C_RESET_VEC || bus.if_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc addr=%h if_pc=%h required=%h/0", bus.imem_addr, bus.if_pc, C_RESET_VEC);
        end
        checks++;
        if (bus.imem_rden !== 1'b0 || bus.if_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rden_valid rden=%b if_valid=%b required=0/0", bus.imem_rden, bus.if_valid);
        end
        checks++;
        if (bus.flush_ifid !== 1'b1 || bus.flush_idex !== 1'b1) begin
            failures++;
            $display("FAIL reset_flush ifid=%b idex=%b required=1/1", bus.flush_ifid, bus.flush_idex);
        end
        checks++;
        if (bus.redirect_cnt !== 32'h0 || bus.misalign_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_status cnt=%0d err=%b required=0/0", bus.redirect_cnt, bus.misalign_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.imem_rden !== 1'b1 || bus.if_valid !== 1'b0 || bus.flush_ifid !== 1'b0) begin
            failures++;
            $display("FAIL boot_outputs rden=%b if_valid=%b flush=%b required=1/0/0",
                     bus.imem_rden, bus.if_valid, bus.flush_ifid);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_a [5];
        logic        seen_valid;
        exp_a = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
        seen_valid = 1'b0;
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.imem_addr !== exp_a[i]) begin
                failures++;
                $display("FAIL seq_addr[%0d] addr=%h required=%h", i, bus.imem_addr, exp_a[i]);
            end
            if (!seen_valid && bus.if_valid === 1'b1) begin
                seen_valid = 1'b1;
                checks++;
                if (bus.if_pc !== 32'h0 || bus.if_instr !== memval(32'h0)) begin
                    failures++;
                    $display("FAIL seq_first_valid if_pc=%h instr=%h required=0/%h",
                             bus.if_pc, bus.if_instr, memval(32'h0));
                end
            end
            clk_edge();
        end
        checks++;
        if (!seen_valid || bus.redirect_cnt !== 32'h0) begin
            failures++;
            $display("FAIL seq_valid_cnt seen_valid=%b cnt=%0d required=1/0", seen_valid, bus.redirect_cnt);
        end
    endtask

    task automatic test_branch();
        advance_to(32'h20);
        bus.branch_tgt = 32'h100;
        drive(1'b1, 3'd2, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.flush_ifid !== 1'b1 || bus.flush_idex !== 1'b1) begin
            failures++;
            $display("FAIL branch_flush ifid=%b idex=%b required=1/1", bus.flush_ifid, bus.flush_idex);
        end
        clk_edge();
        idle();
        @(negedge clk);
        checks++;
        if (bus.imem_addr !== 32'h100 || bus.if_valid !== 1'b0 || bus.flush_ifid !== 1'b0) begin
            failures++;
            $display("FAIL branch_flush_cycle addr=%h if_valid=%b flush=%b required=100/0/0",
                     bus.imem_addr, bus.if_valid, bus.flush_ifid);
        end
        clk_edge();
        checks++;
        if (bus.if_pc !== 32'h100 || bus.if_valid !== 1'b1 || bus.if_instr !== memval(32'h100)) begin
            failures++;
            $display("FAIL branch_target_fetch if_pc=%h if_valid=%b instr=%h required=100/1/%h",
                     bus.if_pc, bus.if_valid, bus.if_instr, memval(32'h100));
        end
        checks++;
        if (bus.redirect_cnt !== 32'd1) begin
            failures++;
            $display("FAIL branch_cnt cnt=%0d required=1", bus.redirect_cnt);
        end
    endtask

    task automatic test_stall();
        bus.jal_tgt = 32'h3C;
        drive(1'b1, 3'd3, 1'b0);
        clk_edge();
        idle();
        clk_edge();
        drive(1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.imem_addr !== 32'h40 || bus.if_pc !== 32'h3C || bus.if_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d] addr=%h if_pc=%h if_valid=%b required=40/3c/1",
                         i, bus.imem_addr, bus.if_pc, bus.if_valid);
            end
            clk_edge();
        end
        idle();
        clk_edge();
        checks++;
        if (bus.imem_addr !== 32'h44 || bus.if_pc !== 32'h40) begin
            failures++;
            $display("FAIL stall_release addr=%h if_pc=%h required=44/40", bus.imem_addr, bus.if_pc);
        end
    endtask

    task automatic test_stall_vs_take();
        logic [31:0] cnt0;
        cnt0 = m_cnt;
        bus.jal_tgt = 32'h200;
        drive(1'b1, 3'd3, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.flush_ifid !== 1'b1 || bus.flush_idex !== 1'b1) begin
            failures++;
            $display("FAIL stall_take_flush ifid=%b idex=%b required=1/1", bus.flush_ifid, bus.flush_idex);
        end
        clk_edge();
        idle();
        checks++;
        if (bus.imem_addr !== 32'h200 || bus.redirect_cnt !== cnt0 + 32'd1) begin
            failures++;
            $display("FAIL stall_take_addr addr=%h cnt=%0d required=200/%0d",
                     bus.imem_addr, bus.redirect_cnt, cnt0 + 32'd1);
        end
        clk_edge();
    endtask

    task automatic test_back_to_back();
        logic [31:0] cnt0;
        cnt0 = m_cnt;
        bus.mtvec = 32'h80;
        bus.mepc  = 32'h24;
        drive(1'b1, 3'd4, 1'b0);
        clk_edge();
        drive(1'b1, 3'd5, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.imem_addr !== 32'h80 || bus.flush_ifid !== 1'b1 || bus.if_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first addr=%h flush=%b if_valid=%b required=80/1/0",
                     bus.imem_addr, bus.flush_ifid, bus.if_valid);
        end
        clk_edge();
        idle();
        checks++;
        if (bus.imem_addr !== 32'h24 || bus.redirect_cnt !== cnt0 + 32'd2) begin
            failures++;
            $display("FAIL b2b_second addr=%h cnt=%0d required=24/%0d",
                     bus.imem_addr, bus.redirect_cnt, cnt0 + 32'd2);
        end
        clk_edge();
        // ex_valid low: pcSource=3 must be ignored
        bus.jal_tgt = 32'h300;
        drive(1'b0, 3'd3, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.flush_ifid !== 1'b0 || bus.flush_idex !== 1'b0) begin
            failures++;
            $display("FAIL bubble_flush ifid=%b idex=%b required=0/0", bus.flush_ifid, bus.flush_idex);
        end
        clk_edge();
        checks++;
        if (bus.imem_addr !== 32'h2C || bus.redirect_cnt !== cnt0 + 32'd2 || bus.if_valid !== 1'b1) begin
            failures++;
            $display("FAIL bubble_no_redirect addr=%h cnt=%0d if_valid=%b required=2c/%0d/1",
                     bus.imem_addr, bus.redirect_cnt, bus.if_valid, cnt0 + 32'd2);
        end
        idle();
    endtask

    task automatic test_wrap();
        bus.jal_tgt = 32'hFFFF_FFF8;
        drive(1'b1, 3'd3, 1'b0);
        clk_edge();
        idle();
        clk_edge();
        clk_edge();
        checks++;
        if (bus.imem_addr !== 32'h0 || bus.if_pc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL pc_wrap addr=%h if_pc=%h required=0/fffffffc", bus.imem_addr, bus.if_pc);
        end
    endtask

    task automatic test_random();
        logic ev, st;
        logic [2:0] src;
        for (int i = 0; i < 400; i++) begin
            bus.jalr_tgt   = $urandom() & 32'hFFFF_FFFC;
            bus.branch_tgt = $urandom() & 32'hFFFF_FFFC;
            bus.jal_tgt    = $urandom() & 32'hFFFF_FFFC;
            bus.mtvec      = $urandom() & 32'hFFFF_FFFC;
            bus.mepc       = $urandom() & 32'hFFFF_FFFC;
            ev  = ($urandom_range(0, 3) == 0);
            src = 3'($urandom_range(0, 7));
            st  = ($urandom_range(0, 3) == 0) && !m_last_take;
            drive(ev, src, st);
            @(negedge clk);
            checks++;
            if (bus.imem_addr !== m_pc || bus.if_pc !== m_if_pc) begin
                failures++;
                $display("FAIL rnd_pc[%0d] addr=%h if_pc=%h required=%h/%h",
                         i, bus.imem_addr, bus.if_pc, m_pc, m_if_pc);
            end
            checks++;
            if (bus.if_valid !== (m_ifv && !m_fault) || bus.flush_ifid !== exp_flush()
                || bus.flush_idex !== exp_flush()) begin
                failures++;
                $display("FAIL rnd_ctrl[%0d] if_valid=%b flush=%b/%b required=%b/%b",
                         i, bus.if_valid, bus.flush_ifid, bus.flush_idex, m_ifv && !m_fault, exp_flush());
            end
            checks++;
            if (bus.redirect_cnt !== m_cnt || bus.misalign_err !== m_err) begin
                failures++;
                $display("FAIL rnd_status[%0d] cnt=%0d err=%b required=%0d/%b",
                         i, bus.redirect_cnt, bus.misalign_err, m_cnt, m_err);
            end
            if (m_ifv && !m_held) begin
                checks++;
                if (bus.if_instr !== memval(m_if_pc)) begin
                    failures++;
                    $display("FAIL rnd_instr[%0d] instr=%h required=%h", i, bus.if_instr, memval(m_if_pc));
                end
            end
            clk_edge();
        end
        idle();
    endtask

    task automatic test_misalign();
        logic [31:0] frozen, cnt0;
        cnt0 = m_cnt;
        bus.jalr_tgt = 32'h102;
        drive(1'b1, 3'd1, 1'b0);
        @(negedge clk);
        frozen = bus.imem_addr;
        checks++;
        if (bus.flush_ifid !== 1'b1 || bus.flush_idex !== 1'b1) begin
            failures++;
            $display("FAIL misalign_flush ifid=%b idex=%b required=1/1", bus.flush_ifid, bus.flush_idex);
        end
        clk_edge();
        idle();
        checks++;
        if (bus.misalign_err !== 1'b1 || bus.imem_rden !== 1'b0 || bus.if_valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_fault err=%b rden=%b if_valid=%b required=1/0/0",
                     bus.misalign_err, bus.imem_rden, bus.if_valid);
        end
        bus.jal_tgt = 32'h400;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd3, 1'($urandom_range(0, 1)));
            clk_edge();
        end
        checks++;
        if (bus.imem_addr !== frozen || bus.redirect_cnt !== cnt0 || bus.flush_idex !== 1'b1) begin
            failures++;
            $display("FAIL misalign_frozen addr=%h cnt=%0d flush=%b required=%h/%0d/1",
                     bus.imem_addr, bus.redirect_cnt, bus.flush_idex, frozen, cnt0);
        end
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.misalign_err !== 1'b0 || bus.imem_addr !== C_RESET_VEC || bus.redirect_cnt !== 32'h0) begin
            failures++;
            $display("FAIL fault_reset err=%b addr=%h cnt=%0d required=0/%h/0",
                     bus.misalign_err, bus.imem_addr, bus.redirect_cnt, C_RESET_VEC);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clk_edge();
        clk_edge();
        checks++;
        if (bus.imem_addr !== C_RESET_VEC + 32'd4 || bus.if_valid !== 1'b1) begin
            failures++;
            $display("FAIL fault_recover addr=%h if_valid=%b required=%h/1",
                     bus.imem_addr, bus.if_valid, C_RESET_VEC + 32'd4);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_stall_vs_take();
        test_back_to_back();
        test_wrap();
        test_random();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
